// File: rtl/division.sv
// Iterative signed 32-bit divider with MIPS div semantics: LO gets the quotient, HI the remainder.
// Restoring shift-subtract on operand magnitudes, one quotient bit per cycle, then sign fix-up.
module division (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [1:0]  stateOut,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        divZero
);

  localparam logic [1:0] StStart = 2'd0;
  localparam logic [1:0] StCalc  = 2'd1;
  localparam logic [1:0] StFix   = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [5:0]  count_q, count_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        div_zero_q, div_zero_d;

  logic [32:0] rem_sh;
  logic [33:0] trial;

  function automatic logic [31:0] mag(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  // Shift {rem,quo} left by one and try subtracting the divisor; bit 33 flags a negative trial.
  assign rem_sh = {rem_q[31:0], quo_q[31]};
  assign trial  = {1'b0, rem_sh} - {2'b00, dvsr_q};

  always_comb begin
    state_d    = state_q;
    dvsr_d     = dvsr_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    count_d    = count_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    unique case (state_q)
      StStart: begin
        if (enable) begin
          if (B == 32'd0) begin
            div_zero_d = 1'b1;
          end else begin
            div_zero_d = 1'b0;
            q_neg_d    = A[31] ^ B[31];
            r_neg_d    = A[31];
            quo_d      = mag(A);
            dvsr_d     = mag(B);
            rem_d      = 33'd0;
            count_d    = 6'd0;
            state_d    = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d   = trial[33] ? rem_sh : trial[32:0];
        quo_d   = {quo_q[30:0], ~trial[33]};
        count_d = count_q + 6'd1;
        if (count_q == 6'd31) state_d = StFix;
      end
      StFix: begin
        if (q_neg_q) quo_d = ~quo_q + 32'd1;
        if (r_neg_q) rem_d = {rem_q[32], ~rem_q[31:0] + 32'd1};
        state_d = StDone;
      end
      StDone: begin
        hi_d    = rem_q[31:0];
        lo_d    = quo_q;
        state_d = StStart;
      end
      default: state_d = StStart;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StStart;
      dvsr_q     <= 32'd0;
      rem_q      <= 33'd0;
      quo_q      <= 32'd0;
      count_q    <= 6'd0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvsr_q     <= dvsr_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      count_q    <= count_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign stateOut = state_q;
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign divZero  = div_zero_q;

endmodule

// File: tb/tb_division.sv
// Directed bench for the iterative divider: latency, signs, overflow, divide-by-zero,
// mid-operation reset and back-to-back throughput with operands changing during CALC.
module tb_division;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [1:0]  state_out;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  division dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .A        (a_in),
    .B        (b_in),
    .stateOut (state_out),
    .HI       (hi),
    .LO       (lo),
    .divZero  (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mag(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  // Truncating signed division reference built from unsigned magnitudes.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    logic [31:0] qm, rm;
    qm = mag(a) / mag(b);
    rm = mag(a) % mag(b);
    q  = (a[31] ^ b[31]) ? (~qm + 32'd1) : qm;
    r  = a[31] ? (~rm + 32'd1) : rm;
  endtask

  // Call at a negedge with state START; returns at the negedge after the DONE edge.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi, input bit hold);
    logic [31:0] st;
    a_in   = a;
    b_in   = b;
    enable = 1'b1;
    @(negedge clock);
    if (!hold) enable = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
    check({tag, " divzero_clear"}, {31'd0, div_zero}, 32'd0);
    check({tag, " state_e0"}, {30'd0, state_out}, 32'd1);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clock);
      st = (k <= 31) ? 32'd1 : (k == 32) ? 32'd2 : (k == 33) ? 32'd3 : 32'd0;
      check({tag, " state"}, {30'd0, state_out}, st);
      if (k == 33) begin
        check({tag, " hi_hold"}, hi, last_hi);
        check({tag, " lo_hold"}, lo, last_lo);
      end
    end
    check({tag, " lo"}, lo, exp_lo);
    check({tag, " hi"}, hi, exp_hi);
    last_lo = exp_lo;
    last_hi = exp_hi;
  endtask

  initial begin
    logic [31:0] ra, rb, rq, rr;
    reset  = 1'b1;
    enable = 1'b0;
    a_in   = 32'd0;
    b_in   = 32'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst state", {30'd0, state_out}, 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    check("rst divzero", {31'd0, div_zero}, 32'd0);

    do_div("7/2", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
    do_div("-7/2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    do_div("7/-2", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
    do_div("-7/-2", 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0);
    do_div("ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
    do_div("bigdiv", 32'h12345678, 32'h80000000, 32'd0, 32'h12345678, 1'b0);
    do_div("7/2b", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0);

    // Divide by zero: rejected, HI/LO untouched, flag sticks while idle.
    a_in   = 32'd5;
    b_in   = 32'd0;
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    check("dz flag", {31'd0, div_zero}, 32'd1);
    check("dz state", {30'd0, state_out}, 32'd0);
    check("dz hi", hi, 32'd1);
    check("dz lo", lo, 32'd3);
    @(negedge clock);
    check("dz flag_hold", {31'd0, div_zero}, 32'd1);
    check("dz state_hold", {30'd0, state_out}, 32'd0);
    do_div("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Reset on the edge of CALC iteration 10 discards the in-flight division.
    a_in   = 32'd100;
    b_in   = 32'd7;
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    repeat (9) @(negedge clock);
    check("mid state_calc", {30'd0, state_out}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid state", {30'd0, state_out}, 32'd0);
    check("mid hi", hi, 32'd0);
    check("mid lo", lo, 32'd0);
    check("mid divzero", {31'd0, div_zero}, 32'd0);
    last_hi = 32'd0;
    last_lo = 32'd0;
    do_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    // Back-to-back with enable held high: period 35 is checked by the per-cycle state sequence.
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd3;
      if (i % 4 == 1) ra = ra >> $urandom_range(0, 31);
      model(ra, rb, rq, rr);
      do_div("rand", ra, rb, rq, rr, (i != 199));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
